// File: rtl/gshare_branch_predictor.sv
// Gshare branch direction predictor: PC XOR speculative global history indexes a
// flop array of saturating counters; execute trains it and restores history on mispredict.
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int CTR_BITS   = 2,
  parameter int PC_LSB     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [HIST_BITS-1:0]  pred_ghr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic [HIST_BITS-1:0]  upd_ghr,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [31:0]           lookup_count,
  output logic [31:0]           mispredict_count
);

  localparam int                  ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [31:0]         PERF_MAX = 32'hFFFF_FFFF;

  logic [CTR_BITS-1:0]   ctrTable_r [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_r;
  logic [HIST_BITS-1:0]  ghrNext_s;
  logic [INDEX_BITS-1:0] predIdx_s;
  logic [31:0]           lookupCount_r;
  logic [31:0]           mispCount_r;
  logic                  restore_s;
  logic                  unusedBits_s;

  // Saturating up/down step of one direction counter.
  function automatic logic [CTR_BITS-1:0] trainCtr(input logic [CTR_BITS-1:0] cur,
                                                   input logic              taken);
    logic [CTR_BITS-1:0] nxt;
    if (taken) begin
      nxt = (cur == CTR_MAX) ? cur : cur + CTR_BITS'(1);
    end else begin
      nxt = (cur == CTR_MIN) ? cur : cur - CTR_BITS'(1);
    end
    return nxt;
  endfunction

  // Shift a new outcome into a history; the truncating cast also covers HIST_BITS = 1.
  function automatic logic [HIST_BITS-1:0] shiftHist(input logic [HIST_BITS-1:0] hist,
                                                     input logic                 newBit);
    return HIST_BITS'({hist, newBit});
  endfunction

  assign predIdx_s    = pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr_r);
  assign pred_index   = predIdx_s;
  assign pred_ghr     = ghr_r;
  assign pred_taken   = ctrTable_r[predIdx_s][CTR_BITS-1];
  assign restore_s    = upd_valid & upd_mispredict;
  assign unusedBits_s = ^{pred_pc, upd_ghr};

  assign lookup_count     = lookupCount_r;
  assign mispredict_count = mispCount_r;

  // Next history: a resolved mispredict wins over the (wrong-path) speculative shift.
  always_comb begin
    ghrNext_s = ghr_r;
    if (restore_s) begin
      ghrNext_s = shiftHist(upd_ghr, upd_taken);
    end else if (pred_valid) begin
      ghrNext_s = shiftHist(ghr_r, pred_taken);
    end else begin
      ghrNext_s = ghr_r;
    end
  end

  // Global history register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_r <= {HIST_BITS{1'b0}};
    end else begin
      ghr_r <= ghrNext_s;
    end
  end

  // Counter table: whole array returns to weakly not-taken in one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctrTable_r[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      ctrTable_r[upd_index] <= trainCtr(ctrTable_r[upd_index], upd_taken);
    end
  end

  // Saturating debug performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      lookupCount_r <= 32'd0;
      mispCount_r   <= 32'd0;
    end else begin
      if (pred_valid && (lookupCount_r != PERF_MAX)) begin
        lookupCount_r <= lookupCount_r + 32'd1;
      end
      if (restore_s && (mispCount_r != PERF_MAX)) begin
        mispCount_r <= mispCount_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: directed plan steps plus random
// traffic against an arithmetic reference model, and a small second-configuration check.
module tb_gshare_branch_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_taken;
  logic [5:0]  pred_index;
  logic [5:0]  pred_ghr;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_index = 6'd0;
  logic [5:0]  upd_ghr = 6'd0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] lookup_count;
  logic [31:0] mispredict_count;

  // second configuration: INDEX_BITS=4, HIST_BITS=2, CTR_BITS=3
  logic        reset2 = 1'b0;
  logic        predTaken2;
  logic [3:0]  predIndex2;
  logic [1:0]  predGhr2;
  logic        updValid2 = 1'b0;
  logic        updTaken2 = 1'b0;
  logic [31:0] lookupCount2;
  logic [31:0] mispCount2;

  always #5 clock = ~clock;

  gshare_branch_predictor #(.INDEX_BITS(6), .HIST_BITS(6), .CTR_BITS(2), .PC_LSB(0)) dut (
    .clock(clock), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_index(pred_index), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .lookup_count(lookup_count), .mispredict_count(mispredict_count)
  );

  gshare_branch_predictor #(.INDEX_BITS(4), .HIST_BITS(2), .CTR_BITS(3), .PC_LSB(0)) dut2 (
    .clock(clock), .reset(reset2), .pred_valid(1'b0), .pred_pc(32'd0),
    .pred_taken(predTaken2), .pred_index(predIndex2), .pred_ghr(predGhr2),
    .upd_valid(updValid2), .upd_index(4'd0), .upd_ghr(2'd0),
    .upd_taken(updTaken2), .upd_mispredict(1'b0),
    .lookup_count(lookupCount2), .mispredict_count(mispCount2)
  );

  int checks = 0;
  int errors = 0;

  // reference model: plain integers
  int     mTbl [64];
  int     mGhr = 0;
  longint mLook = 0;
  longint mMisp = 0;
  bit     mKnown = 1'b0;

  logic       obsTaken;
  logic [5:0] obsIdx;
  logic [5:0] obsGhr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runCycle(input bit rst, input bit pv, input logic [31:0] pc,
                          input bit uv, input int ui, input int ug,
                          input bit ut, input bit um);
    int expIdx;
    bit expTaken;
    @(negedge clock);
    reset = rst; pred_valid = pv; pred_pc = pc;
    upd_valid = uv; upd_index = 6'(ui); upd_ghr = 6'(ug);
    upd_taken = ut; upd_mispredict = um;
    #1;
    expIdx   = int'(pc % 32'd64) ^ mGhr;
    expTaken = (mTbl[expIdx] >= 2);
    obsIdx = pred_index; obsTaken = pred_taken; obsGhr = pred_ghr;
    if (mKnown) begin
      check("pred_index", 32'(pred_index), 32'(expIdx));
      check("pred_taken", 32'(pred_taken), 32'(expTaken));
      check("pred_ghr", 32'(pred_ghr), 32'(mGhr));
      check("lookup_count", lookup_count, 32'(mLook));
      check("mispredict_count", mispredict_count, 32'(mMisp));
    end
    @(posedge clock);
    if (rst) begin
      foreach (mTbl[i]) mTbl[i] = 1;
      mGhr = 0; mLook = 0; mMisp = 0; mKnown = 1'b1;
    end else begin
      if (uv) begin
        if (ut) mTbl[ui] = (mTbl[ui] < 3) ? mTbl[ui] + 1 : 3;
        else    mTbl[ui] = (mTbl[ui] > 0) ? mTbl[ui] - 1 : 0;
      end
      if (uv && um)  mGhr = (ug * 2 + int'(ut)) % 64;
      else if (pv)   mGhr = (mGhr * 2 + int'(expTaken)) % 64;
      if (pv && mLook < 64'hFFFF_FFFF) mLook++;
      if (uv && um && mMisp < 64'hFFFF_FFFF) mMisp++;
    end
    #1;
    reset = 1'b0; pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic step2(input bit rst, input bit uv, input bit ut);
    @(negedge clock);
    reset2 = rst; updValid2 = uv; updTaken2 = ut;
    @(posedge clock);
    #1;
    reset2 = 1'b0; updValid2 = 1'b0;
  endtask

  initial begin
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);

    // first lookup after reset
    runCycle(0, 1, 32'h05, 0, 0, 0, 0, 0);
    check("tp1_idx", 32'(obsIdx), 32'd5);
    check("tp1_taken", 32'(obsTaken), 32'd0);
    check("tp1_ghr", 32'(obsGhr), 32'd0);
    check("tp1_ghr_next", 32'(pred_ghr), 32'd0);
    check("tp1_lookups", lookup_count, 32'd1);

    // saturation upward then floor
    for (int i = 0; i < 3; i++) runCycle(0, 0, 32'h05, 1, 5, 0, 1, 0);
    check("sat_hi_taken", 32'(pred_taken), 32'd1);
    for (int i = 0; i < 4; i++) runCycle(0, 0, 32'h05, 1, 5, 0, 0, 0);
    check("sat_lo_taken", 32'(pred_taken), 32'd0);
    runCycle(0, 0, 32'h05, 1, 5, 0, 1, 0);
    check("floor_hold", 32'(pred_taken), 32'd0);

    // speculative shift with table[5]=table[4]=3
    for (int i = 0; i < 3; i++) runCycle(0, 0, 32'h05, 1, 5, 0, 1, 0);
    for (int i = 0; i < 3; i++) runCycle(0, 0, 32'h05, 1, 4, 0, 1, 0);
    runCycle(0, 1, 32'h05, 0, 0, 0, 0, 0);
    check("spec1_ghr", 32'(obsGhr), 32'd0);
    check("spec1_taken", 32'(obsTaken), 32'd1);
    runCycle(0, 1, 32'h05, 0, 0, 0, 0, 0);
    check("spec2_ghr", 32'(obsGhr), 32'd1);
    check("spec2_idx", 32'(obsIdx), 32'h04);
    check("spec_ghr_after", 32'(pred_ghr), 32'b000011);

    // mispredict restore beats a same-cycle prediction
    runCycle(0, 0, 32'h00, 1, 10, 6'b010101, 0, 1);
    check("restore_setup", 32'(pred_ghr), 32'b101010);
    check("misp_setup", mispredict_count, 32'd1);
    runCycle(0, 1, 32'h00, 1, 10, 6'b000111, 0, 1);
    check("restore_ghr", 32'(pred_ghr), 32'b001110);
    check("restore_misp", mispredict_count, 32'd2);
    check("restore_lookups", lookup_count, 32'd4);

    // read-during-write at index 5 (ghr=0x0E, pc=0x0B)
    for (int i = 0; i < 2; i++) runCycle(0, 0, 32'h0B, 1, 5, 0, 0, 0);
    runCycle(0, 0, 32'h0B, 1, 5, 0, 1, 0);
    check("rdw_idx", 32'(obsIdx), 32'd5);
    check("rdw_old", 32'(obsTaken), 32'd0);
    check("rdw_new", 32'(pred_taken), 32'd1);

    // reset wins over a concurrent update, mispredict and lookup
    runCycle(1, 1, 32'h0B, 1, 5, 6'h3F, 1, 1);
    check("rst_ghr", 32'(pred_ghr), 32'd0);
    check("rst_lookups", lookup_count, 32'd0);
    check("rst_misp", mispredict_count, 32'd0);
    for (int pc = 0; pc < 64; pc++) runCycle(0, 0, 32'(pc), 0, 0, 0, 0, 0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      runCycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), $urandom(),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
    end

    // second configuration: reset value 3, saturation at 7
    step2(1, 0, 0);
    check("cfg2_reset", 32'(predTaken2), 32'd0);
    check("cfg2_ghr", 32'(predGhr2), 32'd0);
    step2(0, 1, 1);
    check("cfg2_one_up", 32'(predTaken2), 32'd1);
    for (int i = 0; i < 5; i++) step2(0, 1, 1);
    for (int i = 0; i < 3; i++) step2(0, 1, 0);
    check("cfg2_sat7", 32'(predTaken2), 32'd1);
    step2(0, 1, 0);
    check("cfg2_down3", 32'(predTaken2), 32'd0);
    check("cfg2_idx", 32'(predIndex2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Parametrised successor to the decode-stage single-table predictor.
- Gshare direction predictor: PC bits XORed with a speculative global history register (GHR) index a table of saturating counters.
- Decode queries it combinationally in the same cycle. The execute stage sends resolved outcomes back for training, plus a GHR restore on mispredict.
- Also keeps lookup and mispredict performance counters for debug.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64).
- HIST_BITS, 6, GHR length; legal range 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width; legal range 1..4.
- PC_LSB, 0, lowest PC bit used in the index (0 for word-addressed PC).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- pred_valid  in  1  decode holds a branch (bne/blt/bex) this cycle.
- pred_pc  in  32  PC of that branch.
- pred_taken  out  1  predicted direction (combinational).
- pred_index  out  INDEX_BITS  table index used; carried down the pipe.
- pred_ghr  out  HIST_BITS  GHR snapshot before this prediction; carried down the pipe.
- upd_valid  in  1  a branch resolved in execute this cycle.
- upd_index  in  INDEX_BITS  index returned from decode.
- upd_ghr  in  HIST_BITS  snapshot returned from decode.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  actual outcome differs from prediction; qualified by upd_valid.
- lookup_count  out  32  number of pred_valid cycles.
- mispredict_count  out  32  number of upd_valid & upd_mispredict cycles.

Behaviour:
- Index: idx = pred_pc[PC_LSB+INDEX_BITS-1:PC_LSB] XOR zero-extended ghr[HIST_BITS-1:0].
- Outputs: pred_index = idx; pred_ghr = ghr; pred_taken = MSB of table[idx]. All are combinational and valid regardless of pred_valid.
- Read-during-write on the same index in the same cycle returns the pre-update value. There is no bypass.
- Counter training, on a clock edge with upd_valid: table[upd_index] increments if upd_taken, else decrements.
  - Saturates at 2^CTR_BITS-1 and at 0. No wrap.
  - Trained regardless of upd_mispredict.
- GHR update, priority order at each edge:
  1. reset: ghr <= 0.
  2. upd_valid & upd_mispredict: ghr <= {upd_ghr[HIST_BITS-2:0], upd_taken}. A simultaneous pred_valid is ignored, since that branch is on the wrong path and is flushed.
  3. pred_valid: ghr <= {ghr[HIST_BITS-2:0], pred_taken} (speculative shift).
  4. Otherwise ghr holds.
  - When HIST_BITS = 1, the shift reduces to ghr <= the new bit.
- Performance counters:
  - lookup_count increments on pred_valid, including the wrong-path lookup that a mispredict squashes.
  - mispredict_count increments on upd_valid & upd_mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Reset, one cycle:
  - Every counter is set to weakly not-taken, value 2^(CTR_BITS-1)-1. For CTR_BITS=1 this is 0.
  - ghr = 0; lookup_count = 0; mispredict_count = 0.
  - Reset overrides a concurrent update or prediction. Outputs reflect the reset state from the next cycle.
- Reset mid-operation: any in-flight update presented in the reset cycle is discarded. Updates after reset are applied normally, even if they carry stale upd_ghr.
- Latency:
  - Prediction is 0 cycles.
  - A training update is visible to a lookup in the next cycle.
  - A GHR restore affects the index in the next cycle.
- Storage is a flop array, so all entries reset in one cycle. No valid bits and no tags; aliasing is accepted.

Test Plan:
- Reset then pred_valid, pred_pc=0x05 -> pred_index=5, pred_taken=0, pred_ghr=0; next cycle ghr=0 and lookup_count=1.
- Three updates at index 5 with upd_taken=1, upd_mispredict=0 -> table[5] goes 1→2→3→3 (saturates); pred_pc=0x05 with ghr=0 then gives pred_taken=1. Four not-taken updates -> 0, stays 0.
- Speculative shift: force table[5]=3, pred_pc=0x05 for two cycles -> pred_ghr 0 then 1; the second lookup uses idx=0x04; ghr=6'b000011 after.
- Mispredict restore: ghr=6'b101010; upd_valid=1, upd_mispredict=1, upd_ghr=6'b000111, upd_taken=0, with pred_valid=1 in the same cycle -> ghr=6'b001110, no speculative bit; mispredict_count increments by 1.
- Same-cycle read/write at index 5: table[5]=1, update taken plus lookup at the same index -> pred_taken=0 that cycle, 1 next cycle.
- Reset asserted alongside an update and a mispredict -> all counters 1, ghr=0, both performance counters 0. Parameter sweep INDEX_BITS=4, HIST_BITS=2, CTR_BITS=3 -> reset value 3, saturation at 7.
